// File: rtl/rf_dump_reader_pkg.sv
// rtl/rf_dump_reader_pkg.sv - shared state encodings and record sizes for the register-file dump reader
package rf_dump_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int REC_BYTES_IDX = 5;
    localparam int REC_BYTES_RAW = 4;

endpackage

// File: rtl/rf_dump_reader_word_serializer.sv
// rtl/rf_dump_reader_word_serializer.sv - emits an optional tag byte plus a 32-bit word MSB-first over valid/ready
module word_serializer
    import rf_dump_reader_pkg::*;
#(
    parameter bit EMIT_TAG = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [7:0]  tag,
    output logic [7:0]  tdata,
    output logic        tvalid,
    input  logic        tready,
    output logic        last_xfer
);

    localparam logic [2:0] LAST_SEL = EMIT_TAG ? 3'(REC_BYTES_IDX - 1) : 3'(REC_BYTES_RAW - 1);

    logic [31:0] shadow;
    logic [7:0]  tag_q;
    logic [2:0]  bsel;
    logic        active;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadow <= '0;
            tag_q  <= '0;
            bsel   <= '0;
            active <= 1'b0;
        end else if (load) begin
            shadow <= word;
            tag_q  <= tag;
            bsel   <= '0;
            active <= 1'b1;
        end else if (active && tready) begin
            if (bsel == LAST_SEL) begin
                active <= 1'b0;
            end else begin
                bsel <= bsel + 3'd1;
            end
        end
    end

    assign tvalid    = active;
    assign last_xfer = active && tready && (bsel == LAST_SEL);

    // Output is forced to zero when idle so the sink never sees a stale byte.
    always_comb begin
        tdata = '0;
        if (active) begin
            if (EMIT_TAG) begin
                case (bsel)
                    3'd0:    tdata = tag_q;
                    3'd1:    tdata = shadow[31:24];
                    3'd2:    tdata = shadow[23:16];
                    3'd3:    tdata = shadow[15:8];
                    3'd4:    tdata = shadow[7:0];
                    default: tdata = '0;
                endcase
            end else begin
                case (bsel)
                    3'd0:    tdata = shadow[31:24];
                    3'd1:    tdata = shadow[23:16];
                    3'd2:    tdata = shadow[15:8];
                    3'd3:    tdata = shadow[7:0];
                    default: tdata = '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/rf_dump_reader.sv
// rtl/rf_dump_reader.sv - walks the register-file debug port and streams each register as a byte record
module rf_dump_reader
    import rf_dump_reader_pkg::*;
#(
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 31,
    parameter int EMIT_INDEX = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  ra_dbg,
    input  logic [31:0] rd_dbg,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    state_t     state, state_nxt;
    logic [4:0] idx;
    logic       ser_load;
    logic       last_xfer;

    // idx is compared before incrementing so LAST_REG=31 never wraps to 0 mid-dump.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            idx   <= FIRST_IDX;
        end else begin
            state <= state_nxt;
            if (state == S_SEND && last_xfer && idx != LAST_IDX) begin
                idx <= idx + 5'd1;
            end else if (state == S_DONE) begin
                idx <= FIRST_IDX;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ser_load  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                ser_load  = 1'b1;
                state_nxt = S_SEND;
            end
            S_SEND: if (last_xfer) state_nxt = (idx == LAST_IDX) ? S_DONE : S_LOAD;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy   = (state != S_IDLE);
    assign ra_dbg = idx;

    word_serializer #(
        .EMIT_TAG (EMIT_INDEX != 0)
    ) u_ser (
        .clk       (clk),
        .rstn      (rstn),
        .load      (ser_load),
        .word      (rd_dbg),
        .tag       ({3'b000, idx}),
        .tdata     (out_data),
        .tvalid    (out_valid),
        .tready    (out_ready),
        .last_xfer (last_xfer)
    );

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb/tb_rf_dump_reader.sv - directed bench for rf_dump_reader across three parameter sets
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  start_v = '0;
    logic [31:0] regs [32];

    logic [4:0]  ra [3];
    logic [31:0] rd [3];
    logic [7:0]  od [3];
    logic        ov [3];
    logic        bz [3];
    logic        dn [3];

    int          sel = 0;
    logic        cur_valid, cur_busy, cur_done;
    logic [7:0]  cur_data;
    logic [4:0]  cur_ra;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  got [$];
    logic [7:0]  exp_full [$];
    int          done_n, first_v, ra_zero, stab_err;

    always #5 clk = ~clk;

    assign rd[0] = regs[ra[0]];
    assign rd[1] = regs[ra[1]];
    assign rd[2] = regs[ra[2]];

    always_comb begin
        cur_valid = ov[sel];
        cur_data  = od[sel];
        cur_busy  = bz[sel];
        cur_done  = dn[sel];
        cur_ra    = ra[sel];
    end

    rf_dump_reader u_full (
        .clk(clk), .rstn(rstn), .start(start_v[0]), .busy(bz[0]), .done(dn[0]),
        .ra_dbg(ra[0]), .rd_dbg(rd[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready)
    );

    rf_dump_reader #(.FIRST_REG(2), .LAST_REG(3), .EMIT_INDEX(0)) u_raw (
        .clk(clk), .rstn(rstn), .start(start_v[1]), .busy(bz[1]), .done(dn[1]),
        .ra_dbg(ra[1]), .rd_dbg(rd[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready)
    );

    rf_dump_reader #(.FIRST_REG(31), .LAST_REG(31), .EMIT_INDEX(1)) u_top (
        .clk(clk), .rstn(rstn), .start(start_v[2]), .busy(bz[2]), .done(dn[2]),
        .ra_dbg(ra[2]), .rd_dbg(rd[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int stream_diff();
        int d = 0;
        if (got.size() != exp_full.size()) d++;
        for (int i = 0; i < got.size() && i < exp_full.size(); i++)
            if (got[i] !== exp_full[i]) d++;
        return d;
    endfunction

    // Entered and left just after a posedge; abort_byte>0 leaves at a negedge instead.
    task automatic run_dump(input int sel_i, input bit rnd, input bit poke,
                            input int mutate_byte, input int abort_byte);
        int n = 0;
        bit held_v = 1'b0;
        logic [7:0] held_d = '0;
        bit aborted = 1'b0;
        sel = sel_i;
        got.delete();
        done_n = 0; first_v = 0; ra_zero = 0; stab_err = 0;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start_v[sel_i] = 1'b1;
        @(posedge clk); #1;
        start_v = '0;
        for (int c = 0; c < 4000 && done_n == 0; c++) begin
            @(negedge clk);
            n++;
            if (first_v == 0 && cur_valid) first_v = n;
            if (cur_done) done_n = n;
            if (cur_busy && cur_ra == 5'd0) ra_zero++;
            if (held_v && (!cur_valid || cur_data !== held_d)) stab_err++;
            held_v = cur_valid && !out_ready;
            held_d = cur_data;
            if (cur_valid && out_ready) begin
                got.push_back(cur_data);
                if (got.size() == mutate_byte) regs[2] = 32'h1;
            end
            if (abort_byte > 0 && got.size() == abort_byte) begin
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
            start_v = '0;
            if (poke && cur_valid && (n % 7 == 0)) start_v[sel_i] = 1'b1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!aborted) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rec2 [5];
        logic [7:0] rec3 [5];
        logic [7:0] raw  [8];
        logic [7:0] top  [5];
        rec2 = '{8'h02, 8'h00, 8'h00, 8'h2F, 8'hFC};
        rec3 = '{8'h03, 8'h00, 8'h00, 8'h18, 8'h00};
        raw  = '{8'h00, 8'h00, 8'h2F, 8'hFC, 8'h00, 8'h00, 8'h18, 8'h00};
        top  = '{8'h1F, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[2] = 32'h2ffc;
        regs[3] = 32'h1800;
        for (int r = 0; r < 32; r++) begin
            exp_full.push_back(8'(r));
            exp_full.push_back(regs[r][31:24]);
            exp_full.push_back(regs[r][23:16]);
            exp_full.push_back(regs[r][15:8]);
            exp_full.push_back(regs[r][7:0]);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bz[0]), 32'h0);
        chk("reset_done", 32'(dn[0]), 32'h0);
        chk("reset_valid", 32'(ov[0]), 32'h0);
        chk("reset_data", 32'(od[0]), 32'h0);
        chk("reset_ra", 32'(ra[0]), 32'h0);
        chk("reset_ra_top", 32'(ra[2]), 32'd31);
        rstn = 1'b1;
        @(posedge clk); #1;

        // 1: full dump, sink always ready
        run_dump(0, 1'b0, 1'b0, 0, 0);
        chk("t1_bytes", 32'(got.size()), 32'd160);
        chk("t1_first_valid", 32'(first_v), 32'd2);
        chk("t1_done_cycle", 32'(done_n), 32'd193);
        chk("t1_stream_diff", 32'(stream_diff()), 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t1_rec2_b%0d", i), 32'(got[10 + i]), 32'(rec2[i]));
            chk($sformatf("t1_rec3_b%0d", i), 32'(got[15 + i]), 32'(rec3[i]));
        end
        chk("t1_busy_after", 32'(bz[0]), 32'h0);
        chk("t1_done_after", 32'(dn[0]), 32'h0);

        // 2: random backpressure
        run_dump(0, 1'b1, 1'b0, 0, 0);
        chk("t2_bytes", 32'(got.size()), 32'd160);
        chk("t2_stream_diff", 32'(stream_diff()), 32'h0);
        chk("t2_stall_stable", 32'(stab_err), 32'h0);
        chk("t2_done_seen", 32'(done_n != 0), 32'h1);

        // 3: raw words, registers 2..3
        run_dump(1, 1'b0, 1'b0, 0, 0);
        chk("t3_bytes", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t3_b%0d", i), 32'(got[i]), 32'(raw[i]));
        chk("t3_done_cycle", 32'(done_n), 32'd11);

        // 4: single record at x31
        regs[31] = 32'hDEADBEEF;
        run_dump(2, 1'b0, 1'b0, 0, 0);
        chk("t4_bytes", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t4_b%0d", i), 32'(got[i]), 32'(top[i]));
        chk("t4_ra_zero", 32'(ra_zero), 32'h0);
        chk("t4_done_cycle", 32'(done_n), 32'd7);
        regs[31] = 32'h0;

        // 5: start pulses while busy, x2 altered after its snapshot
        run_dump(0, 1'b0, 1'b1, 11, 0);
        regs[2] = 32'h2ffc;
        chk("t5_bytes", 32'(got.size()), 32'd160);
        chk("t5_stream_diff", 32'(stream_diff()), 32'h0);
        chk("t5_rec2_b3", 32'(got[13]), 32'h2F);
        chk("t5_rec2_b4", 32'(got[14]), 32'hFC);
        chk("t5_done_cycle", 32'(done_n), 32'd193);

        // 6: reset during record 10, then a fresh dump
        run_dump(0, 1'b0, 1'b0, 0, 53);
        chk("t6_reached_rec10", 32'(got.size()), 32'd53);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("t6_valid_after_rst", 32'(ov[0]), 32'h0);
        chk("t6_busy_after_rst", 32'(bz[0]), 32'h0);
        chk("t6_ra_after_rst", 32'(ra[0]), 32'h0);
        run_dump(0, 1'b0, 1'b0, 0, 0);
        chk("t6_bytes", 32'(got.size()), 32'd160);
        chk("t6_first_index", 32'(got[0]), 32'h00);
        chk("t6_second_index", 32'(got[5]), 32'h01);
        chk("t6_stream_diff", 32'(stream_diff()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
